// File: rtl/haar_lift_mac.sv
// rtl/haar_lift_mac.sv - two-stage Haar butterfly with row/column pass tracker for the 2D DWT
// Optional HAAR_ROUND_EN: round-half-up arithmetic with the high band saturated to 255.

module haar_lift_mac #(
   parameter int HEIGHT              = 256,
   parameter int WIDTH               = 256,
   parameter int DECOMPOSITION_LEVEL = 1,
   localparam int PW                 = $clog2(WIDTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [15:0]   i_mac,
   input  logic          i_mac_valid,
   input  logic          i_mac_mode,
   input  logic [PW-1:0] i_mac_row_column_pointer,
   input  logic [PW-1:0] i_mac_pixel_pointer,
   output logic [15:0]   o_mac,
   output logic          o_mac_valid,
   output logic          o_mac_mode,
   output logic [PW-1:0] o_mac_row_column_pointer,
   output logic [PW-1:0] o_mac_pixel_pointer,
   output logic          o_pass_done,
   output logic [2:0]    o_level,
   output logic          o_done,
   output logic          o_mode_error
);

   typedef enum logic [1:0] {ST_ROW, ST_COL, ST_DONE} state_t;

   state_t              r_state;
   logic [2:0]          r_level;

   logic                r_s1_valid;
   logic [8:0]          r_s1_sum;
   logic signed [8:0]   r_s1_diff;
   logic                r_s1_mode;
   logic [PW-1:0]       r_s1_rc;
   logic [PW-1:0]       r_s1_px;
   logic                r_s1_last;
   logic                r_s1_lvl_inc;
   logic [2:0]          r_s1_level;
   logic                r_s1_done;

   logic [7:0]          w_a;
   logic [7:0]          w_b;
   logic [31:0]         w_px;
   logic [31:0]         w_rc;
   logic [31:0]         w_wl;
   logic [31:0]         w_hl;
   logic                w_mismatch;
   logic                w_row_last;
   logic                w_col_last;
   logic                w_last;
   logic [2:0]          w_next_level;
   logic                w_next_done;
   logic [7:0]          w_low;
   logic [7:0]          w_high;

   assign w_a = i_mac[15:8];
   assign w_b = i_mac[7:0];

   // Active dimensions shrink by half per completed level; pointers compared at 32 bits
   assign w_px = 32'(i_mac_pixel_pointer);
   assign w_rc = 32'(i_mac_row_column_pointer);
   assign w_wl = 32'(WIDTH) >> r_level;
   assign w_hl = 32'(HEIGHT) >> r_level;

   assign w_mismatch   = i_mac_valid &&
                         ((r_state == ST_DONE) || (i_mac_mode != (r_state == ST_COL)));
   assign w_row_last   = (r_state == ST_ROW) && (w_px == w_wl - 32'd2) && (w_rc == w_hl - 32'd1);
   assign w_col_last   = (r_state == ST_COL) && (w_px == w_hl - 32'd2) && (w_rc == w_wl - 32'd1);
   assign w_last       = i_mac_valid && !w_mismatch && (w_row_last || w_col_last);
   assign w_next_level = r_level + 3'd1;
   assign w_next_done  = (32'(w_next_level) == 32'(DECOMPOSITION_LEVEL));

`ifdef HAAR_ROUND_EN
   logic [9:0]          w_sum_rnd;
   logic signed [9:0]   w_diff_rnd;
   logic signed [9:0]   w_high_rnd;

   assign w_sum_rnd  = {1'b0, r_s1_sum} + 10'd1;
   assign w_diff_rnd = {r_s1_diff[8], r_s1_diff} + 10'sd1;
   assign w_high_rnd = (w_diff_rnd >>> 1) + 10'sd128;
   assign w_low      = 8'(w_sum_rnd >> 1);
   // Only a=255,b=0 reaches 256 here
   assign w_high     = (w_high_rnd > 10'sd255) ? 8'hFF : 8'(w_high_rnd);
`else
   assign w_low      = 8'(r_s1_sum >> 1);
   assign w_high     = 8'((r_s1_diff >>> 1) + 9'sd128);
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state                  <= ST_ROW;
         r_level                  <= 3'd0;
         r_s1_valid               <= 1'b0;
         r_s1_sum                 <= '0;
         r_s1_diff                <= '0;
         r_s1_mode                <= 1'b0;
         r_s1_rc                  <= '0;
         r_s1_px                  <= '0;
         r_s1_last                <= 1'b0;
         r_s1_lvl_inc             <= 1'b0;
         r_s1_level               <= 3'd0;
         r_s1_done                <= 1'b0;
         o_mac                    <= 16'd0;
         o_mac_valid              <= 1'b0;
         o_mac_mode               <= 1'b0;
         o_mac_row_column_pointer <= '0;
         o_mac_pixel_pointer      <= '0;
         o_pass_done              <= 1'b0;
         o_level                  <= 3'd0;
         o_done                   <= 1'b0;
         o_mode_error             <= 1'b0;
      end else begin
         if (w_mismatch) begin
            o_mode_error <= 1'b1;
         end

         if (w_last) begin
            if (r_state == ST_ROW) begin
               r_state <= ST_COL;
            end else begin
               r_level <= w_next_level;
               r_state <= w_next_done ? ST_DONE : ST_ROW;
            end
         end

         r_s1_valid <= i_mac_valid;
         if (i_mac_valid) begin
            r_s1_sum     <= {1'b0, w_a} + {1'b0, w_b};
            r_s1_diff    <= $signed({1'b0, w_a}) - $signed({1'b0, w_b});
            r_s1_mode    <= i_mac_mode;
            r_s1_rc      <= i_mac_row_column_pointer;
            r_s1_px      <= i_mac_pixel_pointer;
            r_s1_last    <= w_last;
            r_s1_lvl_inc <= w_last && (r_state == ST_COL);
            r_s1_level   <= w_next_level;
            r_s1_done    <= w_next_done;
         end

         // Level/done reported together with the pass-completing result beat
         o_mac_valid <= r_s1_valid;
         o_pass_done <= r_s1_valid && r_s1_last;
         if (r_s1_valid) begin
            o_mac                    <= {w_low, w_high};
            o_mac_mode               <= r_s1_mode;
            o_mac_row_column_pointer <= r_s1_rc;
            o_mac_pixel_pointer      <= r_s1_px;
            if (r_s1_lvl_inc) begin
               o_level <= r_s1_level;
               if (r_s1_done) begin
                  o_done <= 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_haar_lift_mac.sv
// tb/tb_haar_lift_mac.sv - self-checking bench for haar_lift_mac on an 8x8 image, two levels
// Honours HAAR_ROUND_EN in its reference arithmetic.

module tb_haar_lift_mac;

   localparam int W  = 8;
   localparam int H  = 8;
   localparam int DL = 2;
   localparam int PW = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic [15:0]   i_mac;
   logic          i_mac_valid;
   logic          i_mac_mode;
   logic [PW-1:0] i_mac_row_column_pointer;
   logic [PW-1:0] i_mac_pixel_pointer;
   logic [15:0]   o_mac;
   logic          o_mac_valid;
   logic          o_mac_mode;
   logic [PW-1:0] o_mac_row_column_pointer;
   logic [PW-1:0] o_mac_pixel_pointer;
   logic          o_pass_done;
   logic [2:0]    o_level;
   logic          o_done;
   logic          o_mode_error;

   haar_lift_mac #(.HEIGHT(H), .WIDTH(W), .DECOMPOSITION_LEVEL(DL)) dut (
      .clk                      (clk),
      .rst                      (rst),
      .i_mac                    (i_mac),
      .i_mac_valid              (i_mac_valid),
      .i_mac_mode               (i_mac_mode),
      .i_mac_row_column_pointer (i_mac_row_column_pointer),
      .i_mac_pixel_pointer      (i_mac_pixel_pointer),
      .o_mac                    (o_mac),
      .o_mac_valid              (o_mac_valid),
      .o_mac_mode               (o_mac_mode),
      .o_mac_row_column_pointer (o_mac_row_column_pointer),
      .o_mac_pixel_pointer      (o_mac_pixel_pointer),
      .o_pass_done              (o_pass_done),
      .o_level                  (o_level),
      .o_done                   (o_done),
      .o_mode_error             (o_mode_error)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          v;
      bit [15:0]   d;
      bit          m;
      bit [PW-1:0] rc;
      bit [PW-1:0] px;
      bit          pd;
      int          lvl;
      bit          dn;
   } beat_t;

   beat_t pipe[$];
   int n_checks = 0;
   int n_fail   = 0;
   int n_pd     = 0;

   // Reference tracker: level count, which pass is expected, done, sticky error
   int m_level;
   bit m_col;
   bit m_done;
   bit m_err;

   // Expected (held) output state
   bit [15:0]   e_d;
   bit          e_m;
   bit [PW-1:0] e_rc;
   bit [PW-1:0] e_px;
   int          e_level;
   bit          e_done;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs(input beat_t o);
      if (o.v) begin
         e_d  = o.d;
         e_m  = o.m;
         e_rc = o.rc;
         e_px = o.px;
      end
      if (o.pd) begin
         e_level = o.lvl;
         e_done  = o.dn;
      end
      if (o_pass_done === 1'b1) n_pd++;
      chk("valid",      32'(o_mac_valid),              32'(o.v));
      chk("data",       32'(o_mac),                    32'(e_d));
      chk("mode",       32'(o_mac_mode),               32'(e_m));
      chk("rc_ptr",     32'(o_mac_row_column_pointer), 32'(e_rc));
      chk("px_ptr",     32'(o_mac_pixel_pointer),      32'(e_px));
      chk("pass_done",  32'(o_pass_done),              32'(o.pd));
      chk("level",      32'(o_level),                  32'(e_level));
      chk("done",       32'(o_done),                   32'(e_done));
      chk("mode_error", 32'(o_mode_error),             32'(m_err));
   endtask

   task automatic cycle(input bit v, input int a, input int b, input bit mode,
                        input int rc, input int px);
      beat_t e;
      beat_t o;
      int lo, hi, wl, hl;
      i_mac_valid              = v;
      i_mac                    = {8'(a), 8'(b)};
      i_mac_mode               = mode;
      i_mac_row_column_pointer = PW'(rc);
      i_mac_pixel_pointer      = PW'(px);
`ifdef HAAR_ROUND_EN
      lo = (a + b + 1) / 2;
      hi = (a - b + 257) / 2;
      if (hi > 255) hi = 255;
`else
      lo = (a + b) / 2;
      hi = (a - b + 256) / 2;
`endif
      e.v   = v;
      e.d   = {8'(lo), 8'(hi)};
      e.m   = mode;
      e.rc  = PW'(rc);
      e.px  = PW'(px);
      e.pd  = 1'b0;
      if (v) begin
         if (m_done || (mode != m_col)) begin
            m_err = 1'b1;
         end else begin
            wl = W >> m_level;
            hl = H >> m_level;
            if (!m_col && px == wl - 2 && rc == hl - 1) begin
               e.pd  = 1'b1;
               m_col = 1'b1;
            end else if (m_col && px == hl - 2 && rc == wl - 1) begin
               e.pd    = 1'b1;
               m_col   = 1'b0;
               m_level = m_level + 1;
               if (m_level == DL) m_done = 1'b1;
            end
         end
      end
      e.lvl = m_level;
      e.dn  = m_done;
      pipe.push_back(e);
      @(posedge clk);
      #1;
      o = pipe.pop_front();
      check_outputs(o);
   endtask

   task automatic idle();
      cycle(1'b0, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
            1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
   endtask

   task automatic run_pass(input bit mode, input int lvl);
      int lines, span;
      lines = mode ? (W >> lvl) : (H >> lvl);
      span  = mode ? (H >> lvl) : (W >> lvl);
      for (int ln = 0; ln < lines; ln++) begin
         for (int p = 0; p < span; p += 2) begin
            if ($urandom_range(0, 3) == 0) idle();
            cycle(1'b1, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), mode, ln, p);
         end
      end
   endtask

   task automatic do_reset();
      beat_t z;
      z = '{default: 0};
      rst         = 1'b1;
      i_mac_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst     = 1'b0;
      m_level = 0;
      m_col   = 1'b0;
      m_done  = 1'b0;
      m_err   = 1'b0;
      e_d     = '0;
      e_m     = 1'b0;
      e_rc    = '0;
      e_px    = '0;
      e_level = 0;
      e_done  = 1'b0;
      pipe.delete();
      pipe.push_back(z);
      check_outputs(z);
   endtask

   initial begin
      rst                      = 1'b1;
      i_mac                    = '0;
      i_mac_valid              = 1'b0;
      i_mac_mode               = 1'b0;
      i_mac_row_column_pointer = '0;
      i_mac_pixel_pointer      = '0;
      do_reset();

      // Known coefficient pairs
      cycle(1'b1, 200, 100, 1'b0, 3, 4);
      idle();
      chk("t1_data_const",  32'(o_mac), 32'h96B2);
      chk("t1_valid_const", 32'(o_mac_valid), 32'd1);
      chk("t1_rc_const",    32'(o_mac_row_column_pointer), 32'd3);
      chk("t1_px_const",    32'(o_mac_pixel_pointer), 32'd4);
      idle();
      cycle(1'b1, 0, 255, 1'b0, 1, 2);
      idle();
`ifdef HAAR_ROUND_EN
      chk("t2_a0_b255", 32'(o_mac), 32'h8001);
`else
      chk("t2_a0_b255", 32'(o_mac), 32'h7F00);
`endif
      cycle(1'b1, 255, 0, 1'b0, 2, 0);
      idle();
`ifdef HAAR_ROUND_EN
      chk("t2_a255_b0", 32'(o_mac), 32'h80FF);
`else
      chk("t2_a255_b0", 32'(o_mac), 32'h7FFF);
`endif

      // Random beats with random gaps, never on a last-beat pointer
      for (int i = 0; i < 20; i++) begin
         if ($urandom_range(0, 1) == 1) idle();
         cycle(1'b1, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 1'b0,
               int'($urandom_range(0, 6)), 2 * int'($urandom_range(0, 3)));
      end
      idle();
      idle();

      // Wrong mode while in ROW, carrying last-beat pointers: must not advance
      cycle(1'b1, 10, 20, 1'b1, 7, 6);
      chk("t5_err_next", 32'(o_mode_error), 32'd1);
      idle();
      idle();
      chk("t5_no_pass_done", 32'(n_pd), 32'd0);

      // Level 0: row then column pass
      run_pass(1'b0, 0);
      repeat (3) idle();
      chk("t3_row0_pd", 32'(n_pd), 32'd1);
      chk("t3_row0_lvl", 32'(o_level), 32'd0);
      run_pass(1'b1, 0);
      repeat (3) idle();
      chk("t3_col0_pd", 32'(n_pd), 32'd2);
      chk("t3_col0_lvl", 32'(o_level), 32'd1);
      chk("t3_col0_done", 32'(o_done), 32'd0);

      // Level 1 on the 4x4 LL band
      run_pass(1'b0, 1);
      run_pass(1'b1, 1);
      repeat (3) idle();
      chk("t3_final_pd", 32'(n_pd), 32'd4);
      chk("t3_final_lvl", 32'(o_level), 32'd2);
      chk("t3_final_done", 32'(o_done), 32'd1);

      // Beat after DONE still computed
      cycle(1'b1, 77, 33, 1'b0, 0, 0);
      idle();
      idle();

      // Reset with beats in flight
      cycle(1'b1, 11, 22, 1'b0, 0, 0);
      cycle(1'b1, 33, 44, 1'b0, 0, 2);
      do_reset();
      for (int i = 0; i < 4; i++) begin
         idle();
         chk("t6_no_valid", 32'(o_mac_valid), 32'd0);
      end
      chk("t6_level", 32'(o_level), 32'd0);
      chk("t6_done", 32'(o_done), 32'd0);
      chk("t6_err", 32'(o_mode_error), 32'd0);

      // Fresh row pass after reset behaves from level 0
      run_pass(1'b0, 0);
      repeat (3) idle();
      chk("t6_row_pd", 32'(n_pd), 32'd5);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
